// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with first-word-fall-through read data, occupancy
// count and almost-full/almost-empty flags. Optional sticky errors: FIFO_ERR_STICKY_EN.
module fifo_param #(
    parameter int N_ADDR_BITS = 2,
    parameter int FIFO_WIDTH  = 8,
    parameter int AF_LEVEL    = (1 << N_ADDR_BITS) - 1,
    parameter int AE_LEVEL    = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [FIFO_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    output logic [FIFO_WIDTH-1:0]  rd_data,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [N_ADDR_BITS:0]   count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int DEPTH = 1 << N_ADDR_BITS;
    localparam logic [N_ADDR_BITS:0]   CNT_DEPTH = (N_ADDR_BITS+1)'(DEPTH);
    localparam logic [N_ADDR_BITS:0]   CNT_AF    = (N_ADDR_BITS+1)'(AF_LEVEL);
    localparam logic [N_ADDR_BITS:0]   CNT_AE    = (N_ADDR_BITS+1)'(AE_LEVEL);
    localparam logic [N_ADDR_BITS:0]   CNT_ONE   = (N_ADDR_BITS+1)'(1);
    localparam logic [N_ADDR_BITS-1:0] PTR_ONE   = N_ADDR_BITS'(1);

    logic [FIFO_WIDTH-1:0]  mem [DEPTH];
    logic [N_ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic                   do_wr, do_rd;

    assign empty        = (count == '0);
    assign full         = (count == CNT_DEPTH);
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);

    // A read frees the head slot in the same edge, so a full FIFO still takes a write
    assign do_wr = wr_en & (~full | rd_en);
    assign do_rd = rd_en & ~empty;

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            if (do_wr && !do_rd)
                count <= count + CNT_ONE;
            else if (do_rd && !do_wr)
                count <= count - CNT_ONE;
        end
    end

    // Storage is not cleared on reset
    always_ff @(posedge clk) begin
        if (reset_n && do_wr) mem[wr_ptr] <= wr_data;
    end

`ifdef FIFO_ERR_STICKY_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !rd_en) overflow  <= 1'b1;
            if (rd_en && empty)          underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (DEPTH=4, width 8): directed vector table,
// reset corner case, then random traffic against a queue reference model.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en, rd_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       empty, full, almost_full, almost_empty;
    logic [2:0] count;
    logic       overflow, underflow;

    int ncmp = 0;
    int nerr = 0;

    fifo_param dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] d;
        int         cnt;
        logic       e, f, af, ae;
        logic [7:0] q;
    } vec_t;

    vec_t tbl[$];

`ifdef FIFO_ERR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wr_en = w; rd_en = r; wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int c, input logic e, input logic f,
                             input logic af, input logic ae, input logic [7:0] q);
        chk({tag, " count"}, 32'(count), 32'(c));
        chk({tag, " empty"}, 32'(empty), 32'(e));
        chk({tag, " full"}, 32'(full), 32'(f));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(af));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(ae));
        chk({tag, " rd_data"}, 32'(rd_data), 32'(q));
    endtask

    // Reference model state
    logic [7:0] mq[$];
    logic       m_ovf, m_unf;

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 1, 0, 0, 1, 8'h00);
        chk("reset overflow", 32'(overflow), 0);
        chk("reset underflow", 32'(underflow), 0);
        reset_n = 1'b1;
        step(0, 0, 8'h00);
        chk_state("idle", 0, 1, 0, 0, 1, 8'h00);

        //                wr rd  data   cnt e  f  af ae  rd_data
        tbl.push_back('{1, 0, 8'h11, 1, 0, 0, 0, 1, 8'h11});
        tbl.push_back('{1, 0, 8'h22, 2, 0, 0, 0, 0, 8'h11});
        tbl.push_back('{1, 0, 8'h33, 3, 0, 0, 1, 0, 8'h11});
        tbl.push_back('{1, 0, 8'h44, 4, 0, 1, 1, 0, 8'h11});
        tbl.push_back('{1, 0, 8'h55, 4, 0, 1, 1, 0, 8'h11});
        tbl.push_back('{0, 1, 8'h00, 3, 0, 0, 1, 0, 8'h22});
        tbl.push_back('{0, 1, 8'h00, 2, 0, 0, 0, 0, 8'h33});
        tbl.push_back('{0, 1, 8'h00, 1, 0, 0, 0, 1, 8'h44});
        tbl.push_back('{0, 1, 8'h00, 0, 1, 0, 0, 1, 8'h00});
        tbl.push_back('{1, 0, 8'h11, 1, 0, 0, 0, 1, 8'h11});
        tbl.push_back('{1, 0, 8'h22, 2, 0, 0, 0, 0, 8'h11});
        tbl.push_back('{1, 0, 8'h33, 3, 0, 0, 1, 0, 8'h11});
        tbl.push_back('{1, 0, 8'h44, 4, 0, 1, 1, 0, 8'h11});
        tbl.push_back('{1, 1, 8'h66, 4, 0, 1, 1, 0, 8'h22});
        tbl.push_back('{0, 1, 8'h00, 3, 0, 0, 1, 0, 8'h33});
        tbl.push_back('{0, 1, 8'h00, 2, 0, 0, 0, 0, 8'h44});
        tbl.push_back('{0, 1, 8'h00, 1, 0, 0, 0, 1, 8'h66});
        tbl.push_back('{0, 1, 8'h00, 0, 1, 0, 0, 1, 8'h00});
        tbl.push_back('{1, 1, 8'h77, 1, 0, 0, 0, 1, 8'h77});
        tbl.push_back('{0, 1, 8'h00, 0, 1, 0, 0, 1, 8'h00});
        tbl.push_back('{0, 1, 8'h00, 0, 1, 0, 0, 1, 8'h00});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].d);
            chk_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].e, tbl[i].f,
                      tbl[i].af, tbl[i].ae, tbl[i].q);
            if (i == 4) chk("vec4 overflow", 32'(overflow), 32'(STICKY));
        end
        chk("sticky overflow", 32'(overflow), 32'(STICKY));
        chk("sticky underflow", 32'(underflow), 32'(STICKY));
        repeat (3) step(0, 0, 8'h00);
        chk("underflow held", 32'(underflow), 32'(STICKY));

        // Reset with a concurrent write discards contents and the write
        step(1, 0, 8'hA1);
        step(1, 0, 8'hA2);
        chk("preload count", 32'(count), 2);
        reset_n = 1'b0;
        step(1, 0, 8'hA3);
        reset_n = 1'b1;
        chk_state("midreset", 0, 1, 0, 0, 1, 8'h00);
        chk("midreset overflow", 32'(overflow), 0);
        chk("midreset underflow", 32'(underflow), 0);
        step(0, 0, 8'h00);
        chk_state("postreset", 0, 1, 0, 0, 1, 8'h00);

        // Random traffic against a queue model
        m_ovf = 1'b0; m_unf = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic w, r, m_full, m_empty;
            logic [7:0] d;
            logic [7:0] exp_q;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            d = 8'($urandom);
            m_full  = (mq.size() == 4);
            m_empty = (mq.size() == 0);
            if (w && m_full && !r) m_ovf = STICKY;
            if (r && m_empty)      m_unf = STICKY;
            if (r && !m_empty) void'(mq.pop_front());
            if (w && (!m_full || r)) mq.push_back(d);
            step(w, r, d);
            exp_q = (mq.size() == 0) ? 8'h00 : mq[0];
            chk("rnd count", 32'(count), 32'(mq.size()));
            chk("rnd empty", 32'(empty), 32'(mq.size() == 0));
            chk("rnd full", 32'(full), 32'(mq.size() == 4));
            chk("rnd almost_full", 32'(almost_full), 32'(mq.size() >= 3));
            chk("rnd almost_empty", 32'(almost_empty), 32'(mq.size() <= 1));
            chk("rnd rd_data", 32'(rd_data), 32'(exp_q));
            chk("rnd overflow", 32'(overflow), 32'(m_ovf));
            chk("rnd underflow", 32'(underflow), 32'(m_unf));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO; next generation of the team's 4-entry 2-bit shift-register FIFO.
- Circular buffer with configurable width and power-of-two depth; first-word-fall-through read data.
- Adds occupancy count, programmable almost-full/almost-empty flags and concurrent read+write in the same cycle.
- Sits between producer/consumer blocks in the lab datapath and replaces the fixed 4x2 FIFO.

Parameters:
N_ADDR_BITS, 2, log2 of depth; DEPTH = 1 << N_ADDR_BITS (legal 1..8)
FIFO_WIDTH, 8, data width in bits
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (legal 1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (legal 0..DEPTH-1)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset, sampled on the clk rising edge
wr_en  in  1  write request
wr_data  in  FIFO_WIDTH  write data
rd_en  in  1  read request; pops the current head
rd_data  out  FIFO_WIDTH  head entry (FWFT); valid only while empty=0
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  N_ADDR_BITS+1  current occupancy, 0..DEPTH
overflow  out  1  error flag, see Optional Feature
underflow  out  1  error flag, see Optional Feature

Behaviour:
- Storage: DEPTH x FIFO_WIDTH array, wr_ptr and rd_ptr of N_ADDR_BITS bits, wrap naturally modulo DEPTH; count is a separate register of N_ADDR_BITS+1 bits.
- Reset (reset_n=0 at posedge): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0. Storage is not cleared.
- After reset: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), which is always 0 for legal values; rd_data=0.
- Reset has priority over wr_en/rd_en. Reset mid-operation discards all contents in one cycle.
- Accept rules, evaluated at posedge:
  - do_wr = wr_en & (!full | rd_en)
  - do_rd = rd_en & !empty
- do_wr: mem[wr_ptr] <= wr_data, wr_ptr+1. do_rd: rd_ptr+1.
- count update: +1 if do_wr & !do_rd; -1 if do_rd & !do_wr; unchanged otherwise.
- Simultaneous wr_en and rd_en:
  - empty: write only; count 0 -> 1; rd_data shows the new word the next cycle.
  - full: both accepted; count stays DEPTH; the new word lands in the freed slot, since wr_ptr == rd_ptr.
  - otherwise: both accepted; count unchanged.
- Write when full without rd_en: ignored; contents and pointers unchanged.
- Read when empty: ignored; pointers and count unchanged.
- rd_data = empty ? 0 : mem[rd_ptr], combinational from registers. Latency from accepted write into empty FIFO to visible rd_data: 1 cycle.
- All flags are combinational decodes of count and change only on clock edges.

Optional Feature:
Macro FIFO_ERR_STICKY_EN.
- Defined:
  - overflow sets when wr_en & full & !rd_en at a posedge.
  - underflow sets when rd_en & empty at a posedge.
  - Both flags stay set until reset_n=0.
  - Data path behaviour is identical to the undefined case.
- Undefined:
  - overflow and underflow are tied to 0.
  - No error registers are synthesised.

Test Plan:
- Reset then idle, defaults (DEPTH=4, width 8) -> empty=1, full=0, count=0, almost_empty=1, rd_data=0, overflow=underflow=0.
- Write 0x11,0x22,0x33,0x44 on 4 cycles -> count 1,2,3,4. almost_empty drops after 2nd write. almost_full rises at count=3. full=1 at count=4. rd_data=0x11 throughout.
- FIFO full, write 0x55 with rd_en=0 -> ignored, count=4. With FIFO_ERR_STICKY_EN: overflow=1. Then read 4 times -> rd_data 0x11,0x22,0x33,0x44, then empty=1.
- FIFO full, wr_en=rd_en=1 with 0x66 -> count stays 4. Reads then return 0x22,0x33,0x44,0x66 (pointer wrap).
- Empty, wr_en=rd_en=1 with 0x77 -> count=1, rd_data=0x77 next cycle. Empty rd_en alone -> count stays 0; with macro, underflow=1 and stays 1 until reset_n=0.
- 2 entries loaded, assert reset_n=0 for one cycle with wr_en=1 -> count=0, empty=1, sticky flags cleared, write not accepted.
